// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: turns load-use, branch, I-miss, D-miss and halt conditions into
// per-register enable/flush strobes for the PC and the four pipeline registers.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             memtoReg_EX,
  input  logic [REG_W-1:0] rt_dest_EX,
  input  logic             branch_taken_EX,
  input  logic             ihit,
  input  logic             dmem_req_MEM,
  input  logic             dhit,
  input  logic             halt_WB,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use, dmiss;
  logic do_halt, do_freeze, do_resolve;

  // $0 is hard-wired zero, so a load into it can never feed a dependent instruction.
  assign load_use = memtoReg_EX && (rt_dest_EX != '0) &&
                    ((rt_dest_EX == rs_ID) || (rt_dest_EX == rt_ID));
  assign dmiss    = dmem_req_MEM && !dhit;

  // Classify the cycle once; the output process only maps the class to strobes.
  always_comb begin
    do_halt    = 1'b0;
    do_freeze  = 1'b0;
    do_resolve = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt_WB)    do_halt    = 1'b1;
        else if (dmiss) do_freeze  = 1'b1;
        else            do_resolve = 1'b1;
      end
      MEM_WAIT: begin
        if (halt_WB)    do_halt    = 1'b1;
        else if (!dhit) do_freeze  = 1'b1;
        else            do_resolve = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_WB)    state_d = HALTED;
        else if (dmiss) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (halt_WB)   state_d = HALTED;
        else if (dhit) state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALTED || do_halt) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = (state_q == HALTED);
    end else if (do_freeze) begin
      // Hold everything up to EX/MEM; bubble into MEM/WB while the load waits.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (do_resolve) begin
      if (branch_taken_EX) begin
        // Redirect wins even on an I-miss: the fetched word is wrong-path anyway.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != HALTED && !pc_en && cnt_q != '1)
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle RUN decisions
// plus hand sequences for reset, D-miss, halt and counter saturation.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic [REG_W-1:0] rs_ID, rt_ID, rt_dest_EX;
  logic memtoReg_EX, branch_taken_EX, ihit, dmem_req_MEM, dhit, halt_WB;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .rs_ID(rs_ID), .rt_ID(rt_ID), .memtoReg_EX(memtoReg_EX),
    .rt_dest_EX(rt_dest_EX), .branch_taken_EX(branch_taken_EX), .ihit(ihit),
    .dmem_req_MEM(dmem_req_MEM), .dhit(dhit), .halt_WB(halt_WB),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
  typedef struct {
    string      name;
    logic [4:0] rs, rt, rtd;
    logic       mtr, br, ih, dreq, dh, hlt;
    logic [4:0] en;
    logic [3:0] fl;
    logic       hd;
  } vec_t;

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic mtr,
                              logic [4:0] rtd, logic br, logic ih, logic dreq, logic dh,
                              logic hlt, logic [4:0] en, logic [3:0] fl, logic hd);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.mtr = mtr; v.rtd = rtd; v.br = br;
    v.ih = ih; v.dreq = dreq; v.dh = dh; v.hlt = hlt; v.en = en; v.fl = fl; v.hd = hd;
    return v;
  endfunction

  task automatic check_out(string name, logic [4:0] en, logic [3:0] fl, logic hd);
    logic [4:0] a_en;
    logic [3:0] a_fl;
    a_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    a_fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
    checks++;
    if (a_en !== en || a_fl !== fl || halted !== hd) begin
      failures++;
      $display("FAIL %s: got en=%b fl=%b halted=%b, expected en=%b fl=%b halted=%b",
               name, a_en, a_fl, halted, en, fl, hd);
    end
  endtask

  task automatic check_cnt(string name, int exp);
    checks++;
    if (stall_cnt !== exp[CNT_W-1:0]) begin
      failures++;
      $display("FAIL %s: stall_cnt=%0d expected %0d", name, stall_cnt, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs, clock, then check the counter.
  task automatic run_vec(vec_t v);
    @(negedge CLK);
    nRST = 1'b1;
    rs_ID = v.rs; rt_ID = v.rt; memtoReg_EX = v.mtr; rt_dest_EX = v.rtd;
    branch_taken_EX = v.br; ihit = v.ih; dmem_req_MEM = v.dreq; dhit = v.dh; halt_WB = v.hlt;
    #1 check_out(v.name, v.en, v.fl, v.hd);
    @(posedge CLK);
    #1;
    if (!v.hd && v.en[4] == 1'b0 && exp_cnt < 15) exp_cnt++;
    check_cnt({v.name, "_cnt"}, exp_cnt);
  endtask

  task automatic do_reset(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      nRST = 1'b0;
      ihit = 1'b1; dmem_req_MEM = 1'b0; dhit = 1'b0; halt_WB = 1'b0;
      branch_taken_EX = 1'b0; memtoReg_EX = 1'b0;
      #1 check_out("reset_out", 5'b00000, 4'b1111, 1'b0);
      @(posedge CLK);
    end
    #1 check_cnt("reset_cnt", 0);
    exp_cnt = 0;
  endtask

  vec_t tbl[10];
  vec_t normal, freeze;

  initial begin
    nRST = 1'b0; rs_ID = '0; rt_ID = '0; rt_dest_EX = '0; memtoReg_EX = 1'b0;
    branch_taken_EX = 1'b0; ihit = 1'b1; dmem_req_MEM = 1'b0; dhit = 1'b0; halt_WB = 1'b0;

    normal = mk("normal", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0);
    freeze = mk("dmiss", 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00001, 4'b0001, 0);

    tbl[0] = mk("t_normal",      1, 2, 0, 0,  0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0);
    tbl[1] = mk("t_lu_rs",       8, 3, 1, 8,  0, 1, 0, 0, 0, 5'b00111, 4'b0100, 0);
    tbl[2] = mk("t_lu_rt",       4, 9, 1, 9,  0, 1, 0, 0, 0, 5'b00111, 4'b0100, 0);
    tbl[3] = mk("t_lu_r0",       0, 0, 1, 0,  0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0);
    tbl[4] = mk("t_lu_nomatch",  8, 9, 1, 10, 0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0);
    tbl[5] = mk("t_br_imiss_lu", 8, 0, 1, 8,  1, 0, 0, 0, 0, 5'b11111, 4'b1100, 0);
    tbl[6] = mk("t_imiss",       1, 2, 0, 0,  0, 0, 0, 0, 0, 5'b01111, 4'b1000, 0);
    tbl[7] = mk("t_dreq_hit",    1, 2, 0, 0,  0, 1, 1, 1, 0, 5'b11111, 4'b0000, 0);
    tbl[8] = mk("t_lu_imiss",    7, 7, 1, 7,  0, 0, 0, 0, 0, 5'b00111, 4'b0100, 0);
    tbl[9] = mk("t_noload",      8, 8, 0, 8,  0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0);

    // Reset, then release with ihit=1.
    do_reset(2);
    run_vec(normal);

    foreach (tbl[i]) run_vec(tbl[i]);

    // D-miss with a simultaneous taken branch: freeze wins for 3 cycles.
    do_reset(1);
    for (int i = 0; i < 3; i++)
      run_vec(mk("dmiss_br", 0, 0, 0, 0, 1, 1, 1, 0, 0, 5'b00001, 4'b0001, 0));
    // dhit cycle resolves the held branch (ihit=0 does not block the redirect).
    run_vec(mk("dhit_br", 0, 0, 0, 0, 1, 0, 1, 1, 0, 5'b11111, 4'b1100, 0));
    check_cnt("dmiss_total", 3);
    // Back in RUN: dhit=0 without a request must not freeze.
    run_vec(mk("after_dhit_run", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0));

    // Plain D-miss then dhit.
    do_reset(1);
    for (int i = 0; i < 3; i++) run_vec(freeze);
    run_vec(mk("dhit", 0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b11111, 4'b0000, 0));
    check_cnt("dmiss3_cnt", 3);

    // Halt arriving during MEM_WAIT, then absorbing with toggled inputs.
    do_reset(1);
    run_vec(freeze);
    run_vec(mk("halt_in_wait", 0, 0, 0, 0, 0, 1, 1, 0, 1, 5'b00000, 4'b0000, 0));
    exp_cnt = 15; // counter not re-checked while halted; suppress model increments below
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ihit = i[0]; branch_taken_EX = ~i[0]; dmem_req_MEM = i[1]; dhit = ~i[1];
      halt_WB = i[0]; memtoReg_EX = 1'b1; rt_dest_EX = 5'd3; rs_ID = 5'd3;
      #1 check_out("halted_hold", 5'b00000, 4'b0000, 1'b1);
    end
    do_reset(1);
    run_vec(normal);

    // Reset in the middle of MEM_WAIT returns to RUN.
    do_reset(1);
    run_vec(freeze);
    do_reset(1);
    run_vec(mk("post_wait_rst", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b0000, 0));

    // Saturation at 2^CNT_W-1 = 15.
    do_reset(1);
    for (int i = 0; i < 20; i++)
      run_vec(mk("sat_imiss", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 4'b1000, 0));
    check_cnt("sat_final", 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
